// File: rtl/pcap_dma_writer.sv
// pcap_dma_writer: drains the framed PCAP sample stream into host buffers through an AXI write master.
// Define PCAP_DMA_TIMEOUT_EN to build the idle-flush timeout (flag[2]); otherwise timeout_i is ignored.
module pcap_dma_writer #(
  parameter int BURST_LEN  = 16,
  parameter int ADDR_DEPTH = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        abort_i,
  input  logic [31:0] sample_data_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  input  logic        last_i,
  input  logic [31:0] dma_addr_i,
  input  logic        dma_addr_wstb_i,
  input  logic [15:0] block_size_i,
  input  logic [31:0] timeout_i,
  input  logic        irq_ack_i,
  output logic [31:0] m_awaddr_o,
  output logic [7:0]  m_awlen_o,
  output logic        m_awvalid_o,
  input  logic        m_awready_i,
  output logic [31:0] m_wdata_o,
  output logic        m_wlast_o,
  output logic        m_wvalid_o,
  input  logic        m_wready_i,
  input  logic [1:0]  m_bresp_i,
  input  logic        m_bvalid_i,
  output logic        m_bready_o,
  output logic        irq_o,
  output logic [31:0] irq_status_o,
  output logic        busy_o
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int FCW = FAW + 1;
  localparam int AAW = $clog2(ADDR_DEPTH);
  localparam int ACW = AAW + 1;
  localparam logic [FAW:0] C_FIFO_FULL = FIFO_DEPTH[FAW:0];
  localparam logic [FAW:0] C_BURST     = BURST_LEN[FAW:0];
  localparam logic [AAW:0] C_AQ_FULL   = ADDR_DEPTH[AAW:0];
  localparam logic [7:0]   C_BURST8    = BURST_LEN[7:0];

  typedef enum logic [2:0] {
    S_IDLE, S_NEXTBUF, S_COLLECT, S_AW, S_W, S_B, S_IRQ, S_DONE
  } state_t;

  state_t       r_state;
  logic [31:0]  r_fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0] r_fifo_wr, r_fifo_rd;
  logic [FAW:0] r_fifo_cnt;
  logic [31:0]  r_aq_mem [ADDR_DEPTH];
  logic [AAW-1:0] r_aq_wr, r_aq_rd;
  logic [AAW:0] r_aq_cnt;
  logic [31:0]  r_cur_addr, r_awaddr, r_wdata, r_irq_status;
  logic [15:0]  r_buf_words;
  logic [7:0]   r_len, r_beat, r_awlen;
  logic [4:0]   r_flags;
  logic         r_last_seen, r_abort, r_enable_d, r_busy, r_irq;
  logic         r_awvalid, r_wvalid, r_wlast, r_bready;

  logic         w_fifo_push, w_fifo_pop, w_fifo_flush;
  logic         w_aq_push, w_aq_pop, w_aq_flush;
  logic         w_abort, w_flush_abort, w_timeout;
  logic [15:0]  w_words_next;

  assign sample_ready_o = r_busy && (r_fifo_cnt != C_FIFO_FULL);
  assign w_fifo_push    = sample_valid_i && sample_ready_o;
  // Only the AW handshake and non-final W beats pop, so a burst pops exactly len words.
  assign w_fifo_pop     = (r_state == S_AW && m_awready_i) ||
                          (r_state == S_W && m_wready_i && r_beat != r_len);
  assign w_abort        = r_abort || abort_i;
  assign w_flush_abort  = w_abort && (r_state == S_NEXTBUF || r_state == S_COLLECT ||
                                      (r_state == S_B && m_bvalid_i));
  assign w_fifo_flush   = w_flush_abort || r_state == S_DONE;
  assign w_aq_flush     = w_flush_abort || (r_state == S_DONE && r_abort);
  assign w_aq_pop       = r_state == S_NEXTBUF && !w_abort && r_aq_cnt != '0;
  assign w_aq_push      = dma_addr_wstb_i && (r_aq_cnt != C_AQ_FULL || w_aq_pop);
  assign w_words_next   = r_buf_words + {8'h00, r_len};

`ifdef PCAP_DMA_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      r_to_cnt <= '0;
    else if (r_state != S_COLLECT || w_fifo_push || r_fifo_cnt == '0 || r_fifo_cnt >= C_BURST)
      r_to_cnt <= '0;
    else if (!w_timeout)
      r_to_cnt <= r_to_cnt + 32'd1;
  end
  assign w_timeout = (timeout_i != 32'd0) && (r_to_cnt >= timeout_i);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^timeout_i;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (w_fifo_push) r_fifo_mem[r_fifo_wr] <= sample_data_i;
    if (w_aq_push)   r_aq_mem[r_aq_wr]     <= dma_addr_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_fifo_wr <= '0; r_fifo_rd <= '0; r_fifo_cnt <= '0;
      r_aq_wr   <= '0; r_aq_rd   <= '0; r_aq_cnt   <= '0;
    end else begin
      if (w_fifo_flush) begin
        r_fifo_wr <= '0; r_fifo_rd <= '0; r_fifo_cnt <= '0;
      end else begin
        if (w_fifo_push) r_fifo_wr <= r_fifo_wr + FAW'(1);
        if (w_fifo_pop)  r_fifo_rd <= r_fifo_rd + FAW'(1);
        case ({w_fifo_push, w_fifo_pop})
          2'b10:   r_fifo_cnt <= r_fifo_cnt + FCW'(1);
          2'b01:   r_fifo_cnt <= r_fifo_cnt - FCW'(1);
          default: r_fifo_cnt <= r_fifo_cnt;
        endcase
      end
      if (w_aq_flush) begin
        r_aq_wr <= '0; r_aq_rd <= '0; r_aq_cnt <= '0;
      end else begin
        if (w_aq_push) r_aq_wr <= r_aq_wr + AAW'(1);
        if (w_aq_pop)  r_aq_rd <= r_aq_rd + AAW'(1);
        case ({w_aq_push, w_aq_pop})
          2'b10:   r_aq_cnt <= r_aq_cnt + ACW'(1);
          2'b01:   r_aq_cnt <= r_aq_cnt - ACW'(1);
          default: r_aq_cnt <= r_aq_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_cur_addr <= '0; r_awaddr <= '0; r_wdata <= '0; r_irq_status <= '0;
      r_buf_words <= '0; r_len <= '0; r_beat <= '0; r_awlen <= '0; r_flags <= '0;
      r_last_seen <= 1'b0; r_abort <= 1'b0; r_enable_d <= 1'b0; r_busy <= 1'b0;
      r_irq <= 1'b0; r_awvalid <= 1'b0; r_wvalid <= 1'b0; r_wlast <= 1'b0; r_bready <= 1'b0;
    end else begin
      r_enable_d <= enable_i;
      if (w_fifo_push && last_i) r_last_seen <= 1'b1;
      if (abort_i && r_state != S_IDLE) r_abort <= 1'b1;
      case (r_state)
        S_IDLE: if (enable_i && !r_enable_d) begin
          r_buf_words <= '0; r_last_seen <= 1'b0; r_flags <= '0; r_abort <= 1'b0;
          r_busy <= 1'b1; r_state <= S_NEXTBUF;
        end
        S_NEXTBUF:
          if (w_abort) r_state <= S_IRQ;
          else if (r_aq_cnt != '0) begin
            r_cur_addr <= r_aq_mem[r_aq_rd]; r_buf_words <= '0; r_state <= S_COLLECT;
          end else begin
            r_flags[3] <= 1'b1; r_state <= S_IRQ;
          end
        S_COLLECT:
          if (w_abort) r_state <= S_IRQ;
          else if (r_fifo_cnt >= C_BURST) begin
            r_len <= C_BURST8; r_awlen <= C_BURST8 - 8'd1;
            r_awaddr <= r_cur_addr + {14'h0, r_buf_words, 2'b00};
            r_awvalid <= 1'b1; r_state <= S_AW;
          end else if (r_fifo_cnt != '0 && (r_last_seen || w_timeout)) begin
            // Short flush burst: the end of the capture, or an idle timeout
            if (!r_last_seen) r_flags[2] <= 1'b1;
            r_len <= 8'(r_fifo_cnt); r_awlen <= 8'(r_fifo_cnt) - 8'd1;
            r_awaddr <= r_cur_addr + {14'h0, r_buf_words, 2'b00};
            r_awvalid <= 1'b1; r_state <= S_AW;
          end else if (r_last_seen) begin
            r_flags[1] <= 1'b1; r_state <= S_IRQ;
          end
        S_AW: if (m_awready_i) begin
          r_awvalid <= 1'b0; r_wvalid <= 1'b1; r_wdata <= r_fifo_mem[r_fifo_rd];
          r_beat <= 8'd1; r_wlast <= (r_len == 8'd1); r_state <= S_W;
        end
        S_W: if (m_wready_i) begin
          if (r_beat == r_len) begin
            r_wvalid <= 1'b0; r_wlast <= 1'b0; r_bready <= 1'b1; r_state <= S_B;
          end else begin
            r_wdata <= r_fifo_mem[r_fifo_rd]; r_beat <= r_beat + 8'd1;
            r_wlast <= (r_beat + 8'd1 == r_len);
          end
        end
        S_B: if (m_bvalid_i) begin
          r_bready <= 1'b0; r_buf_words <= w_words_next;
          if (m_bresp_i != 2'b00) begin
            r_flags[4] <= 1'b1; r_state <= S_IRQ;
          end else if (w_abort) r_state <= S_IRQ;
          else if (w_words_next == block_size_i) begin
            r_flags[0] <= 1'b1; r_state <= S_IRQ;
          end else if (r_flags[2]) r_state <= S_IRQ;
          else if (r_last_seen && r_fifo_cnt == '0) begin
            r_flags[1] <= 1'b1; r_state <= S_IRQ;
          end else r_state <= S_COLLECT;
        end
        S_IRQ:
          if (!r_irq) begin
            r_irq <= 1'b1;
            r_irq_status <= {8'h00, r_buf_words, 2'b00, w_abort, r_flags};
          end else if (irq_ack_i) begin
            r_irq <= 1'b0; r_irq_status <= '0; r_flags <= '0;
            // Only a full buffer or a timeout flush lets the capture move to the next buffer
            if (!w_abort && !r_last_seen && r_flags[4:3] == 2'b00 && !r_flags[1])
              r_state <= S_NEXTBUF;
            else
              r_state <= S_DONE;
          end
        S_DONE: begin
          r_busy <= 1'b0; r_abort <= 1'b0; r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_awaddr_o   = r_awaddr;
  assign m_awlen_o    = r_awlen;
  assign m_awvalid_o  = r_awvalid;
  assign m_wdata_o    = r_wdata;
  assign m_wlast_o    = r_wlast;
  assign m_wvalid_o   = r_wvalid;
  assign m_bready_o   = r_bready;
  assign irq_o        = r_irq;
  assign irq_status_o = r_irq_status;
  assign busy_o       = r_busy;
endmodule

// File: tb/tb_pcap_dma_writer.sv
// Scoreboard bench for pcap_dma_writer: expected bursts and beats are queued as stimulus is driven
// and compared when the AXI slave model sees the DUT handshake them.
module tb_pcap_dma_writer;
  logic        clk_i = 1'b0, reset_n_i = 1'b0, enable_i = 1'b0, abort_i = 1'b0;
  logic [31:0] sample_data_i = '0;
  logic        sample_valid_i = 1'b0, sample_ready_o, last_i = 1'b0;
  logic [31:0] dma_addr_i = '0;
  logic        dma_addr_wstb_i = 1'b0;
  logic [15:0] block_size_i = 16'd32;
  logic [31:0] timeout_i = '0;
  logic        irq_ack_i = 1'b0;
  logic [31:0] m_awaddr_o, m_wdata_o, irq_status_o;
  logic [7:0]  m_awlen_o;
  logic        m_awvalid_o, m_awready_i = 1'b0, m_wlast_o, m_wvalid_o, m_wready_i = 1'b0;
  logic [1:0]  m_bresp_i = 2'b00;
  logic        m_bvalid_i = 1'b0, m_bready_o, irq_o, busy_o;

  pcap_dma_writer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .abort_i(abort_i),
    .sample_data_i(sample_data_i), .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .last_i(last_i), .dma_addr_i(dma_addr_i), .dma_addr_wstb_i(dma_addr_wstb_i),
    .block_size_i(block_size_i), .timeout_i(timeout_i), .irq_ack_i(irq_ack_i),
    .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .irq_o(irq_o), .irq_status_o(irq_status_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_errors = 0;
  logic [31:0] exp_aw_addr[$];
  logic [7:0]  exp_aw_len[$];
  logic [31:0] exp_wdata[$];
  logic [1:0]  next_bresp = 2'b00;
  bit          stall = 1'b0;
  int          aw_count = 0, w_beats = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // AXI slave model; everything is decided on the falling edge for the rising edge that follows
  int  cur_len = 0, w_idx = 0;
  bit  pend_b = 1'b0, b_taken = 1'b0;
  always @(negedge clk_i) begin
    if (b_taken) begin m_bvalid_i = 1'b0; b_taken = 1'b0; end
    if (!m_bvalid_i && pend_b) begin m_bvalid_i = 1'b1; m_bresp_i = next_bresp; pend_b = 1'b0; end
    if (m_bvalid_i && m_bready_o) b_taken = 1'b1;

    m_awready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (reset_n_i && m_awvalid_o && m_awready_i) begin
      aw_count++;
      check("aw_expected", 32'(exp_aw_addr.size() != 0), 32'd1);
      if (exp_aw_addr.size() != 0) begin
        check("awaddr", m_awaddr_o, exp_aw_addr.pop_front());
        check("awlen", {24'h0, m_awlen_o}, {24'h0, exp_aw_len.pop_front()});
      end
      cur_len = int'(m_awlen_o) + 1;
      w_idx = 0;
    end

    m_wready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (reset_n_i && m_wvalid_o && m_wready_i) begin
      check("w_expected", 32'(exp_wdata.size() != 0), 32'd1);
      if (exp_wdata.size() != 0) check("wdata", m_wdata_o, exp_wdata.pop_front());
      check("wlast", {31'h0, m_wlast_o}, {31'h0, w_idx == cur_len - 1});
      w_idx++;
      w_beats++;
      if (m_wlast_o) pend_b = 1'b1;
    end
  end

  task automatic push_addr(input logic [31:0] a);
    dma_addr_i = a; dma_addr_wstb_i = 1'b1;
    @(negedge clk_i);
    dma_addr_wstb_i = 1'b0;
  endtask

  task automatic expect_burst(input logic [31:0] a, input logic [7:0] awlen);
    exp_aw_addr.push_back(a);
    exp_aw_len.push_back(awlen);
  endtask

  task automatic send_samples(input int n, input logic [31:0] base, input bit with_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      sample_valid_i = 1'b1; sample_data_i = base + 32'(i); last_i = with_last && (i == n - 1);
      exp_wdata.push_back(base + 32'(i));
      while (!sample_ready_o && guard < 1000) begin @(negedge clk_i); guard++; end
      if (guard >= 1000) begin
        check("sample_accept_timeout", 32'(guard), 32'd0);
        sample_valid_i = 1'b0; last_i = 1'b0;
        return;
      end
      @(negedge clk_i);
    end
    sample_valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input logic [31:0] exp);
    int guard = 0;
    while (!irq_o && guard < 3000) begin @(negedge clk_i); guard++; end
    check({tag, "_irq"}, {31'h0, irq_o}, 32'd1);
    check(tag, irq_status_o, exp);
    irq_ack_i = 1'b1;
    @(negedge clk_i);
    irq_ack_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_irq_clr"}, {31'h0, irq_o}, 32'd0);
    check({tag, "_status_clr"}, irq_status_o, 32'd0);
  endtask

  task automatic wait_not_busy(input string tag);
    int guard = 0;
    while (busy_o && guard < 100) begin @(negedge clk_i); guard++; end
    check(tag, {31'h0, busy_o}, 32'd0);
  endtask

  task automatic disarm();
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  int  aw_snap, g;
  bit  seen;
  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_awvalid", {31'h0, m_awvalid_o}, 32'd0);
    check("rst_wvalid", {31'h0, m_wvalid_o}, 32'd0);
    check("rst_irq", {31'h0, irq_o}, 32'd0);
    check("rst_busy", {31'h0, busy_o}, 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_ready", {31'h0, sample_ready_o}, 32'd0);
    check("rst_status", irq_status_o, 32'd0);

    // Normal: two full bursts fill the first buffer, then a short tail lands in the second
    push_addr(32'h1000); push_addr(32'h2000);
    expect_burst(32'h1000, 8'd15); expect_burst(32'h1040, 8'd15);
    enable_i = 1'b1;
    send_samples(32, 32'd0, 1'b0);
    wait_irq("normal_status", 32'h0000_2001);
    repeat (10) @(negedge clk_i);
    check("normal_busy_after_ack", {31'h0, busy_o}, 32'd1);
    check("normal_no_aw_after_ack", 32'(aw_count), 32'd2);
    expect_burst(32'h2000, 8'd2);
    send_samples(3, 32'h200, 1'b1);
    wait_irq("tail_status", 32'h0000_0302);
    wait_not_busy("tail_busy");
    disarm();

    // Short last, with a stray ack while no interrupt is pending
    push_addr(32'h3000);
    expect_burst(32'h3000, 8'd4);
    enable_i = 1'b1;
    irq_ack_i = 1'b1; @(negedge clk_i); irq_ack_i = 1'b0;
    send_samples(5, 32'h100, 1'b1);
    wait_irq("short_status", 32'h0000_0502);
    wait_not_busy("short_busy");
    disarm();

    // No buffer queued; enable stays high and must not retrigger
    enable_i = 1'b1;
    wait_irq("nobuf_status", 32'h0000_0008);
    @(negedge clk_i);
    sample_valid_i = 1'b1; sample_data_i = 32'hDEAD;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sample_ready_o || busy_o) seen = 1'b1;
      @(negedge clk_i);
    end
    sample_valid_i = 1'b0;
    check("nobuf_ready_after_done", {31'h0, seen}, 32'd0);
    disarm();

    // Error response ends the capture
    push_addr(32'h4000);
    expect_burst(32'h4000, 8'd15);
    next_bresp = 2'b10;
    enable_i = 1'b1;
    send_samples(16, 32'h400, 1'b0);
    wait_irq("axierr_status", 32'h0000_1010);
    next_bresp = 2'b00;
    aw_snap = aw_count;
    repeat (20) @(negedge clk_i);
    check("axierr_no_more_aw", 32'(aw_count), 32'(aw_snap));
    check("axierr_irq_quiet", {31'h0, irq_o}, 32'd0);
    check("axierr_busy", {31'h0, busy_o}, 32'd0);
    disarm();

    // Abort during the data phase; the burst still completes
    push_addr(32'h6000); push_addr(32'h7000);
    expect_burst(32'h6000, 8'd15);
    stall = 1'b1;
    aw_snap = w_beats;
    enable_i = 1'b1;
    fork
      send_samples(16, 32'h600, 1'b0);
      begin
        g = 0;
        while (w_beats < aw_snap + 3 && g < 3000) begin @(negedge clk_i); g++; end
        abort_i = 1'b1; @(negedge clk_i); abort_i = 1'b0;
      end
    join
    wait_irq("abort_status", 32'h0000_1020);
    check("abort_all_beats", 32'(w_beats - aw_snap), 32'd16);
    wait_not_busy("abort_busy");
    stall = 1'b0;
    disarm();
    // The queued 0x7000 must have been flushed
    enable_i = 1'b1;
    wait_irq("abort_queue_flushed", 32'h0000_0008);
    disarm();

`ifdef PCAP_DMA_TIMEOUT_EN
    // Idle timeout flushes a short burst, then the capture moves to the next buffer
    push_addr(32'h8000); push_addr(32'h9000);
    timeout_i = 32'd100;
    stall = 1'b1;
    expect_burst(32'h8000, 8'd2);
    enable_i = 1'b1;
    send_samples(3, 32'h800, 1'b0);
    wait_irq("timeout_status", 32'h0000_0304);
    expect_burst(32'h9000, 8'd0);
    send_samples(1, 32'h900, 1'b1);
    wait_irq("timeout_next_status", 32'h0000_0102);
    wait_not_busy("timeout_busy");
    stall = 1'b0;
    timeout_i = '0;
    disarm();
`endif

    repeat (10) @(negedge clk_i);
    check("aw_queue_drained", 32'(exp_aw_addr.size()), 32'd0);
    check("w_queue_drained", 32'(exp_wdata.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
